reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port we  input  1  write enable for the write port.
REQ-006 SHALL have port waddr  input  ADDR_W  write register index.
REQ-007 SHALL have port wdata  input  DATA_W  write data.
REQ-008 SHALL have port raddr_a  input  ADDR_W  read port A index.
REQ-009 SHALL have port raddr_b  input  ADDR_W  read port B index.
REQ-010 SHALL have port rdata_a  output  DATA_W  read port A data.
REQ-011 SHALL have port rdata_b  output  DATA_W  read port B data.

Function
REQ-012 SHALL decode waddr into a one-hot per-register select, asserted only when we=1 and waddr!=0.
REQ-013 SHALL, per bit of every register, choose next value = select ? wdata bit : current bit (select-gate recirculation); unselected registers hold.
REQ-014 SHALL update the selected register on the rising clk edge; write latency 1 cycle.
REQ-015 SHALL hardwire register 0 to all-zeros; writes to index 0 are silently discarded, and reads of index 0 return 0.
REQ-016 SHALL provide combinational reads: rdata_a/rdata_b reflect register contents for the current raddr_a/raddr_b with zero cycle latency.
REQ-017 SHALL support raddr_a == raddr_b (both ports return the same value) and read/write to different indices in the same cycle without interaction.
REQ-018 SHALL, for read index == waddr with we=1 in the same cycle, behave per REQ-023/REQ-024.
REQ-019 SHALL keep at most one register updated per cycle; no X propagation from unaddressed registers.

Reset
REQ-020 SHALL clear all registers to 0 immediately on rst assertion, independent of clk.
REQ-021 SHALL drive rdata_a and rdata_b to 0 while rst=1, for any read index.
REQ-022 SHALL discard a write whose clock edge coincides with rst=1; the first write honoured is on the first rising edge with rst=0.

Configuration
REQ-023 With REG_FILE_BYPASS_EN defined, a read port whose index equals waddr (nonzero) while we=1 SHALL return wdata combinationally in the same cycle (write-before-read forwarding).
REQ-024 Without REG_FILE_BYPASS_EN, that read port SHALL return the old register value; the new value appears the cycle after the write edge.

Structure
REQ-025 SHALL take DATA_W, ADDR_W defaults and the zero-register index constant from the shared package reg_file_pkg.
REQ-026 SHALL instantiate one sub-module reg_cell per register: DATA_W-bit flop with asynchronous active-high clear and a load select built from per-bit select gates.
REQ-027 SHALL keep the read mux and bypass logic in reg_file, not in reg_cell.

Verification
REQ-028 Reset: assert rst mid-run after writing r5=0xDEADBEEF -> rdata_a (raddr_a=5) reads 0x00000000 immediately, before the next clk edge.
REQ-029 Write/read: we=1, waddr=7, wdata=0x12345678, edge -> raddr_a=7 and raddr_b=7 both read 0x12345678; r6, r8 remain 0.
REQ-030 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF, edge -> raddr_a=0 reads 0x00000000.
REQ-031 Hold: write r3=0xA5A5A5A5, then 10 cycles we=0 with random waddr/wdata -> r3 still 0xA5A5A5A5.
REQ-032 Same-cycle read of write target: r9=0x11111111, then we=1, waddr=9, wdata=0x22222222, raddr_a=9 -> before edge reads 0x22222222 with REG_FILE_BYPASS_EN, 0x11111111 without; after edge 0x22222222 in both.
REQ-033 Reset/write collision: rst=1 across an edge with we=1, waddr=4, wdata=0x55 -> after rst release r4 reads 0x00000000.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the register file: default data/address widths and the
// index of the hardwired zero register. A small helper tells generate code
// whether a given index is the zero register.
// ----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Register at this index is hardwired to zero; writes to it are dropped.
    localparam int ZERO_IDX = 0;

    function automatic bit is_zero_reg(input int idx);
        return (idx == ZERO_IDX);
    endfunction

endpackage : reg_file_pkg

// File: rtl/reg_cell.sv
// ----------------------------------------------------------------------------
// reg_cell
// One register of the register file. Each bit recirculates its own value
// unless the cell's load select is asserted, in which case it takes the
// incoming data bit. Asynchronous active-high clear.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high clear
//   i_sel  in   load select for this register
//   i_d    in   DATA_W load data
//   o_q    out  DATA_W register contents
// ----------------------------------------------------------------------------
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_next;

    // Per-bit select gate: AND-OR mux between new data and recirculated bit.
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        assign w_next[b] = (i_sel & i_d[b]) | (~i_sel & r_q[b]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule : reg_cell

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 2**ADDR_W x DATA_W register file with one write port and two combinational
// read ports. Register ZERO_IDX is hardwired to zero. While rst is high all
// registers are cleared and both read ports return zero.
//
// Optional feature (macro REG_FILE_BYPASS_EN):
//   defined   - a read port addressing the register being written this cycle
//               returns wdata combinationally (write-before-read forwarding)
//   undefined - that read port returns the old contents; the new value shows
//               up after the write edge
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   we       in   write enable
//   waddr    in   ADDR_W write index
//   wdata    in   DATA_W write data
//   raddr_a  in   ADDR_W read port A index
//   raddr_b  in   ADDR_W read port B index
//   rdata_a  out  DATA_W read port A data
//   rdata_b  out  DATA_W read port B data
// ----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_q [DEPTH];

    // One cell per register; the zero register has no storage at all, so a
    // write to it is dropped simply by never having a select for it.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (is_zero_reg(i)) begin : g_zero
            assign w_q[i] = '0;
        end else begin : g_cell
            logic w_sel;

            assign w_sel = we && (waddr == ADDR_W'(i));

            reg_cell #(
                .DATA_W (DATA_W)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .i_sel (w_sel),
                .i_d   (wdata),
                .o_q   (w_q[i])
            );
        end
    end

    logic w_fwd_a;
    logic w_fwd_b;

`ifdef REG_FILE_BYPASS_EN
    logic w_wr_live;

    // Only a real write (nonzero target) is forwarded; a read of the zero
    // register must stay zero even while someone writes index zero.
    assign w_wr_live = we && !is_zero_reg(int'(waddr));
    assign w_fwd_a   = w_wr_live && (raddr_a == waddr);
    assign w_fwd_b   = w_wr_live && (raddr_b == waddr);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    // Reset forces zero on the outputs directly so forwarded wdata cannot
    // leak out while the array is being held clear.
    always_comb begin
        rdata_a = '0;
        if (!rst) begin
            rdata_a = w_fwd_a ? wdata : w_q[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (!rst) begin
            rdata_b = w_fwd_b ? wdata : w_q[raddr_b];
        end
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [32];

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file u_dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endfunction

    // Expected combinational read value given current tb-driven inputs.
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (rst) return '0;
        if (idx == 0) return '0;
        if (BYPASS && we && waddr == idx) return wdata;
        return mem[idx];
    endfunction

    // Drive one cycle from a negedge: check both read ports before the edge,
    // take the edge, update the model, then drop we.
    task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        #1;
        check("pre_a", rdata_a, model_read(ra));
        check("pre_b", rdata_b, model_read(rb));
        @(posedge clk);
        if (!rst && we && waddr != 0) mem[waddr] = wdata;
        #1;
        we = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        raddr_a = idx;
        #1;
        check(tag, rdata_a, exp);
    endtask

    initial begin
        model_clear();

        // Reset state: reads zero while rst held, across two edges.
        repeat (2) @(posedge clk);
        #1;
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D;
        raddr_a = 5'd3; raddr_b = 5'd17;
        #1;
        check("rst_a", rdata_a, 32'h0);
        check("rst_b", rdata_b, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_r3", rdata_a, 32'h0);

        // Write/read on both ports, neighbours untouched.
        cycle(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
        raddr_b = 5'd7;
        peek("wr7_a", 5'd7, 32'h1234_5678);
        check("wr7_b", rdata_b, 32'h1234_5678);
        peek("wr7_r6", 5'd6, 32'h0);
        peek("wr7_r8", 5'd8, 32'h0);

        // Zero register ignores writes.
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        peek("zero_reg", 5'd0, 32'h0);

        // Hold: r3 survives 10 cycles of we=0 with random address/data.
        cycle(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd0);
        for (int k = 0; k < 10; k++)
            cycle(1'b0, 5'($urandom_range(0, 31)), $urandom, 5'd3, 5'($urandom_range(0, 31)));
        peek("hold_r3", 5'd3, 32'hA5A5_A5A5);

        // Same-cycle read of the write target.
        cycle(1'b1, 5'd9, 32'h1111_1111, 5'd0, 5'd0);
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h2222_2222; raddr_a = 5'd9; raddr_b = 5'd0;
        #1;
        check("raw_pre", rdata_a, BYPASS ? 32'h2222_2222 : 32'h1111_1111);
        check("raw_zero_b", rdata_b, 32'h0);
        @(posedge clk);
        mem[9] = 32'h2222_2222;
        #1;
        we = 1'b0;
        peek("raw_post", 5'd9, 32'h2222_2222);

        // Bypass must never forward onto a read of register 0.
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_0000; raddr_a = 5'd0;
        #1;
        check("fwd_zero", rdata_a, 32'h0);
        we = 1'b0;

        // Asynchronous reset mid-cycle clears r5 before any clock edge.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        @(negedge clk);
        raddr_a = 5'd5;
        #1;
        check("r5_before", rdata_a, 32'hDEAD_BEEF);
        rst = 1'b1;
        model_clear();
        #1;
        check("async_rst", rdata_a, 32'h0);

        // Write colliding with reset is discarded.
        we = 1'b1; waddr = 5'd4; wdata = 32'h55; raddr_a = 5'd4;
        @(posedge clk);
        #1;
        check("coll_in_rst", rdata_a, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        peek("coll_r4", 5'd4, 32'h0);
        peek("coll_r5", 5'd5, 32'h0);
        peek("coll_r7", 5'd7, 32'h0);

        // Randomised traffic with occasional reset pulses.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                model_clear();
                we = 1'b1; waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
                raddr_a = waddr; raddr_b = 5'($urandom_range(0, 31));
                #1;
                check("rnd_rst_a", rdata_a, 32'h0);
                check("rnd_rst_b", rdata_b, 32'h0);
                @(negedge clk);
                we = 1'b0;
                rst = 1'b0;
            end else begin
                logic [4:0] wa;
                logic [4:0] ra;
                wa = 5'($urandom_range(0, 31));
                // Bias read A toward the write target to exercise forwarding.
                ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
                cycle($urandom_range(0, 2) != 0, wa, $urandom, ra, 5'($urandom_range(0, 31)));
            end
        end

        // Final sweep of every register against the model.
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #1;
            check("sweep_a", rdata_a, model_read(5'(i)));
            check("sweep_b", rdata_b, model_read(5'(31 - i)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_reg_file
